// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the register-file write request type.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// DEPTH-entry synchronous FIFO holding MDU results (destination + data)
// until the register-file write port is free.
module rf_wb_fifo
    import cpu_pkg::REG_ADDR_W;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [REG_ADDR_W-1:0]  i_addr,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic [REG_ADDR_W-1:0]  o_head_addr,
    output logic [DATA_W-1:0]      o_head_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [REG_ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0]     r_data_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr_mem[r_wptr] <= i_addr;
            r_data_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_head_addr = r_addr_mem[r_rptr];
    assign o_head_data = r_data_mem[r_rptr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB always wins, MDU results queue in a FIFO,
// pending scoreboard stalls decode. Define RF_WB_BYPASS_EN for 0-cycle MDU bypass.
module rf_wb_arbiter
    import cpu_pkg::REG_ADDR_W;
    import cpu_pkg::REG_ZERO;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [REG_ADDR_W-1:0]  mdu_addr,
    input  logic [DATA_W-1:0]      mdu_data,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_addr,
    input  logic [REG_ADDR_W-1:0]  rs_addr,
    input  logic [REG_ADDR_W-1:0]  rt_addr,
    output logic                   stall,
    output logic                   rf_we,
    output logic [REG_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [31:0]           r_pending;
    logic [31:0]           w_pend_next;
    logic [SW-1:0]         r_starve;
    logic                  w_starve_force;
    logic                  w_wb_win;
    logic                  w_mdu_acc;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_count;
    logic [REG_ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0]     w_head_data;
    logic                  w_clr;
    logic [REG_ADDR_W-1:0] w_clr_addr;

    assign w_wb_win  = wb_valid && (wb_addr != REG_ZERO);
    assign mdu_ready = (w_count < FULL_C);
    assign w_mdu_acc = mdu_valid && mdu_ready;
`ifdef RF_WB_BYPASS_EN
    assign w_bypass  = w_mdu_acc && (mdu_addr != REG_ZERO) && w_fifo_empty
                       && !w_wb_win && !reset;
`else
    assign w_bypass  = 1'b0;
`endif
    assign w_push    = w_mdu_acc && (mdu_addr != REG_ZERO) && !w_bypass;
    assign w_pop     = !w_wb_win && !w_fifo_empty;
    assign buf_count = w_count;

    rf_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_addr      (mdu_addr),
        .i_data      (mdu_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_empty     (w_fifo_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_wb_win) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (!w_fifo_empty) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_addr;
            rf_wdata = w_head_data;
        end else if (w_bypass) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_addr;
            rf_wdata = mdu_data;
        end
    end

    assign w_starve_force = (r_starve == SW'(STARVE_MAX));
    assign stall = r_pending[rs_addr] || r_pending[rt_addr]
                || (issue_valid && r_pending[issue_addr]) || w_starve_force;

    assign w_clr      = w_pop || w_bypass;
    assign w_clr_addr = w_pop ? w_head_addr : mdu_addr;

    // Clear is applied before set so a same-cycle set of the same bit wins.
    always_comb begin
        w_pend_next = r_pending;
        if (w_clr) w_pend_next[w_clr_addr] = 1'b0;
        if (issue_valid && !stall && (issue_addr != REG_ZERO))
            w_pend_next[issue_addr] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_starve  <= '0;
        end else begin
            r_pending <= w_pend_next;
            if (w_pop)
                r_starve <= '0;
            else if (!w_fifo_empty && w_wb_win && !w_starve_force)
                r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writers: the pipeline WB stage and a long-latency multiply/divide unit (MDU).
- WB always wins the port. MDU results wait in a small holding FIFO until the port is free.
- A 32-entry pending scoreboard tracks destinations of issued MDU ops and raises a decode-stage stall on RAW or WAW hazards.
- Sits between the WB/MDU outputs and the register file's RegWrite / Write_register / Write_data inputs.

Parameters:
- DEPTH, 2, MDU holding FIFO entries (power of two, ≥2)
- DATA_W, 32, register data width
- STARVE_MAX, 4, cycles a non-empty FIFO head may lose the port before a forced stall

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_valid  in  1  pipeline WB write request
- wb_addr  in  5  pipeline destination register
- wb_data  in  DATA_W  pipeline write data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept an MDU result
- mdu_addr  in  5  MDU destination register
- mdu_data  in  DATA_W  MDU result
- issue_valid  in  1  decode issues an MDU op this cycle
- issue_addr  in  5  destination of the issued MDU op
- rs_addr  in  5  decode source register 1
- rt_addr  in  5  decode source register 2
- stall  out  1  freeze fetch/decode and inject a bubble
- rf_we  out  1  to register file RegWrite
- rf_waddr  out  5  to register file Write_register
- rf_wdata  out  DATA_W  to register file Write_data
- buf_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: FIFO empty, buf_count=0, pending=0, starve counter=0. mdu_ready=1, stall=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- Reset mid-operation drops buffered results and pending bits; the MDU must be flushed alongside.
- Port select (combinational, same cycle):
  - wb_valid && wb_addr!=0: drive the WB triple, rf_we=1.
  - Else, FIFO non-empty: drive the head entry, rf_we=1, pop at the clock edge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- MDU push:
  - mdu_ready = (buf_count < DEPTH), computed from current occupancy only. When full, mdu_ready=0 even if a pop occurs that cycle.
  - Accept on mdu_valid && mdu_ready.
  - mdu_addr==0 results are accepted but never enqueued.
- Latency: an accepted MDU result reaches the register file no earlier than the next cycle (1 cycle minimum). Push and pop in the same cycle leave buf_count unchanged.
- FIFO ordering is strict; read/write pointers wrap modulo DEPTH.
- Scoreboard (pending[31:0]):
  - Set pending[issue_addr] when issue_valid && !stall && issue_addr!=0.
  - Clear a bit when its entry is popped to the register file.
  - Same-cycle set and clear of one bit: set wins.
  - pending[0] is always 0.
- stall = any of:
  - pending[rs_addr]
  - pending[rt_addr]
  - issue_valid && pending[issue_addr]
  - starve_force
- Starvation:
  - The starve counter increments each cycle the FIFO is non-empty and WB holds the port; it resets on any pop.
  - At STARVE_MAX the counter saturates and starve_force=1; it stays high until the next pop.
  - The pipeline must deliver bubbles, so wb_valid=0 eventually.
- WB writing a register whose pending bit is set is legal. The later MDU write overwrites it; WAW ordering is the scoreboard's job via issue stall.

Optional Feature:
- RF_WB_BYPASS_EN defined: when the FIFO is empty and WB does not hold the port, an accepted MDU result (addr!=0) is driven to the register file in the same cycle, skips the FIFO, and clears its pending bit at the edge. 0-cycle latency.
- Undefined: all MDU results pass through the FIFO; minimum latency is 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0
  - a wb_req struct typedef {valid, addr, data}
- Sub-module rf_wb_fifo: DEPTH-entry sync FIFO with push/pop/count/head, instantiated once. Scoreboard, starve counter and port mux stay in the top.

Test Plan:
- Reset: hold reset with mdu_valid=1 → rf_we=0, buf_count=0, mdu_ready=1. Release, push ($8,0x11) → next cycle rf_we=1, rf_waddr=8, rf_wdata=0x11.
- Contention: wb_valid=1 ($3,0xA) and MDU push ($5,0xB) same cycle → port writes $3. Next cycle, wb_valid=0 → port writes $5/0xB, buf_count returns to 0.
- Backpressure: wb_valid=1 continuously, 3 MDU pushes → first two accepted, mdu_ready=0 at buf_count=2. After 4 losing cycles stall=1. Drop wb_valid → pops in order, stall clears after the first pop.
- Scoreboard: issue $9, then rs_addr=9 → stall=1 until the $9 result is written, then 0 the following cycle. Issue $9 again while pending → stall=1, pending unchanged.
- Zero register: issue_addr=0 and mdu push to $0 → no stall, buf_count stays 0, rf_we never 1 for $0.
- RF_WB_BYPASS_EN: empty FIFO, wb_valid=0, push ($4,0x44) → rf_we=1, rf_waddr=4 in the same cycle. Without the macro → write appears the next cycle.
